// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, WB control
// field layout and the load-use detection helper.
package hazard_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        LDUSE   = 3'd1,
        MEMWAIT = 3'd2,
        HALT    = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam int         REG_WRITE_BIT = 2;
    localparam logic [1:0] SRC_MEM       = 2'b11;

    // A load in EX whose destination is read by the instruction in ID.
    function automatic logic is_load_use(
        input logic [2:0] wb_ctrl,
        input logic       rs_vld,
        input logic [2:0] rs,
        input logic       rt_vld,
        input logic [2:0] rt,
        input logic [2:0] dst
    );
        return wb_ctrl[REG_WRITE_BIT] && (wb_ctrl[1:0] == SRC_MEM) &&
               ((rs_vld && (rs == dst)) || (rt_vld && (rt == dst)));
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit data-memory wait counter; timeout fires on the MEM_TIMEOUT-th counted
// cycle so the FSM can leave MEMWAIT on that same edge.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic timeout
);

    localparam logic [7:0] TC = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = run && (count_q == TC);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: holds, bubbles and flushes for load-use,
// redirects, memory waits and halt. HAZ_PERF_CNT_EN adds stall/flush counters.
//
// state   | meaning
// RUN     | normal flow, all hazards evaluated
// LDUSE   | one-cycle load-use bubble in flight, load-use not re-checked
// MEMWAIT | data memory busy, pipeline frozen, timeout counting
// HALT    | halt retired, frozen until reset
// ERR     | memory timeout, frozen until reset
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_rs_vld,
    input  logic       id_rt_vld,
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic [2:0] ex_wb_ctrl,
    input  logic [2:0] ex_dst_reg,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_done,
    input  logic       wb_halt,
    output logic       hold_pc,
    output logic       hold_ifid,
    output logic       hold_idex,
    output logic       hold_back,
    output logic       bubble_idex,
    output logic       flush_ifid,
    output logic       halted,
    output logic       mem_err,
    output logic [2:0] state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    state_t state_q;
    state_t state_d;

    logic [3:0] holds_c;
    logic       bubble_c;
    logic       flush_c;
    logic       load_use;
    logic       mem_stall;
    logic       tmr_run;
    logic       tmr_clear;
    logic       tmr_timeout;

    assign load_use  = is_load_use(ex_wb_ctrl, id_rs_vld, id_rs, id_rt_vld, id_rt, ex_dst_reg);
    assign mem_stall = mem_req && !mem_done;

    assign tmr_run   = (state_q == MEMWAIT) && !mem_done;
    assign tmr_clear = (state_q != MEMWAIT) || mem_done;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (tmr_run),
        .clear   (tmr_clear),
        .timeout (tmr_timeout)
    );

    always_comb begin
        state_d  = state_q;
        holds_c  = 4'b0000;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        case (state_q)
            RUN, LDUSE: begin
                if (wb_halt) begin
                    state_d = HALT;
                end else if (mem_stall) begin
                    holds_c = 4'b1111;
                    state_d = MEMWAIT;
                end else if (ex_redirect) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_d  = RUN;
                end else if (load_use && (state_q == RUN)) begin
                    holds_c  = 4'b1100;
                    bubble_c = 1'b1;
                    state_d  = LDUSE;
                end else begin
                    state_d = RUN;
                end
            end
            // The completing cycle releases the pipeline; the frozen EX
            // contents are judged afresh in RUN on the following cycle.
            MEMWAIT: begin
                if (mem_done) begin
                    state_d = RUN;
                end else begin
                    holds_c = 4'b1111;
                    if (tmr_timeout) begin
                        state_d = ERR;
                    end
                end
            end
            HALT, ERR: begin
                holds_c = 4'b1111;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Mealy outputs would otherwise follow the inputs while reset is held.
    assign hold_pc     = rst && holds_c[3];
    assign hold_ifid   = rst && holds_c[2];
    assign hold_idex   = rst && holds_c[1];
    assign hold_back   = rst && holds_c[0];
    assign bubble_idex = rst && bubble_c && !holds_c[1];
    assign flush_ifid  = rst && flush_c && !holds_c[2];
    assign halted      = (state_q == HALT);
    assign mem_err     = (state_q == ERR);
    assign state       = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;
    logic [15:0] flush_q;
    logic [15:0] flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (hold_pc && ((state_q == RUN) || (state_q == LDUSE) || (state_q == MEMWAIT)) &&
            (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        if (flush_ifid && (flush_q != 16'hFFFF)) begin
            flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule
